// File: rtl/ov7670_pkg.sv
// Shared types and default geometry for the OV7670 capture path.
// The frame-buffer address map is row-major, with address 0 at the top-left pixel.
package ov7670_pkg;
  localparam int HREZ_DEF     = 640;
  localparam int VREZ_DEF     = 480;
  localparam int ADDR_W_DEF   = 19;
  localparam int FRAME_PIXELS = HREZ_DEF * VREZ_DEF;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    WAIT_FR = 2'd1,
    FRAME   = 2'd2
  } cap_state_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection.
// Level, rise and fall all come from the same aligned stage.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], d_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/ov7670_capture.sv
// Oversamples the OV7670 pixel bus in the clk24 domain and keeps the Y bytes of the YUV422 stream.
// Each kept byte is written to the frame buffer as a 4-bit grey pixel.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int HREZ   = HREZ_DEF,
  parameter int VREZ   = VREZ_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk24,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              frame_we,
  output logic [ADDR_W-1:0] frame_waddr,
  output logic [3:0]        frame_wdata,
  output logic              frame_done,
  output logic              overflow,
  output cap_state_t        dbg_state
);
  localparam int NPIX  = HREZ * VREZ;
  localparam int CNT_W = ADDR_W + 1;

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic href_lvl, href_rise, href_fall;
  logic unused_sync;

  sync_edge u_sync_pclk (.clk_i(clk24), .rst_ni(rst_n), .d_i(cam_pclk),
                         .level_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall));
  sync_edge u_sync_vs   (.clk_i(clk24), .rst_ni(rst_n), .d_i(cam_vsync),
                         .level_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall));
  sync_edge u_sync_href (.clk_i(clk24), .rst_ni(rst_n), .d_i(cam_href),
                         .level_o(href_lvl), .rise_o(href_rise), .fall_o(href_fall));

  assign unused_sync = &{pclk_lvl, pclk_fall, href_rise, href_fall};

  cap_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_data_q, wr_data_d;
  logic [7:0]        data_s1_q, data_s2_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [3:0]        wdata_q;

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_VS;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      data_s1_q <= cam_data;
      data_s2_q <= data_s1_q;
      // A write already in flight is dropped if capture is switched off under it.
      we_q      <= wr_q & capture_en;
      if (wr_q && capture_en) begin
        waddr_q <= wr_addr_q;
        wdata_q <= wr_data_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (!capture_en) begin
      state_d = WAIT_VS;
    end else begin
      case (state_q)
        WAIT_VS: if (vs_lvl) state_d = WAIT_FR;
        WAIT_FR: begin
          if (vs_fall) begin
            state_d = FRAME;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            phase_d = 1'b0;
          end
        end
        FRAME: begin
          // The end of the frame takes priority over a byte arriving in the same cycle.
          if (vs_rise) begin
            state_d = WAIT_FR;
            done_d  = 1'b1;
          end else if (!href_lvl) begin
            phase_d = 1'b0;
          end else if (pclk_rise) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
              if (cnt_q == CNT_W'(NPIX)) begin
                ovf_d = 1'b1;
              end else begin
                wr_d      = 1'b1;
                wr_addr_d = cnt_q[ADDR_W-1:0];
                wr_data_d = data_s2_q[7:4];
                cnt_d     = cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_d = WAIT_VS;
      endcase
    end
  end

  assign frame_we    = we_q;
  assign frame_waddr = waddr_q;
  assign frame_wdata = wdata_q;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;
endmodule
